matrix_ram_reader: RTL and testbench

- Read-side sequencer for the team's distributed matrix RAM: drives the RAM read address (addrb) and consumes its read data (doutb).
- Walks a num_rows x num_cols tile starting at base_addr, in row-major or transposed (column-major) order.
- Compensates for the RAM's fixed 2-cycle read latency and presents the data as a valid/ready stream with a last marker.
- A credit-controlled output FIFO absorbs backpressure, so no read data is ever dropped.

---
 rtl/matrix_ram_reader.sv | 217 +++++++++++++++++++++
 tb/tb_matrix_ram_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_ram_reader.sv
// Read sequencer for the distributed matrix RAM: walks a tile row- or column-major,
// hides the RAM read latency and streams the words out through a credit-guarded FIFO.
module matrix_ram_reader #(
   parameter int DATA_WIDTH = 64,
   parameter int ADNW       = 6,
   parameter int DIMW       = 6,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  transpose,
   input  logic [ADNW-1:0]       base_addr,
   input  logic [DIMW-1:0]       num_rows,
   input  logic [DIMW-1:0]       num_cols,
   output logic [ADNW-1:0]       ram_addrb,
   input  logic [DATA_WIDTH-1:0] ram_doutb,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + RD_LAT) + 1;
   localparam logic [DIMW-1:0] ONE = 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  transpose_q, transpose_d;
   logic [ADNW-1:0]       base_q, base_d;
   logic [DIMW-1:0]       rows_q, rows_d;
   logic [DIMW-1:0]       cols_q, cols_d;
   logic [DIMW-1:0]       r_q, r_d;
   logic [DIMW-1:0]       c_q, c_d;
   logic [ADNW-1:0]       addr_q, addr_d;
   logic [RD_LAT-1:0]     pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0]     pipe_last_q, pipe_last_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last_q;

   logic                  accept, in_idle, dims_zero, credit_ok, issue_fire, is_last;
   logic                  push, pop;
   logic                  cur_tr;
   logic [ADNW-1:0]       cur_base, cur_addr;
   logic [DIMW-1:0]       cur_rows, cur_cols, cur_r, cur_c, nxt_r, nxt_c;
   logic [2*DIMW-1:0]     prod;
   logic [CW-1:0]         inflight, occupancy;

   // The accept cycle itself issues element 0 from the raw inputs, so the walk
   // coordinates are muxed between the live inputs (IDLE) and the captured config.
   always_comb begin
      in_idle   = (state_q == S_IDLE);
      accept    = in_idle && start && !rst;
      dims_zero = (num_rows == '0) || (num_cols == '0);
      cur_tr    = in_idle ? transpose : transpose_q;
      cur_base  = in_idle ? base_addr : base_q;
      cur_rows  = in_idle ? num_rows  : rows_q;
      cur_cols  = in_idle ? num_cols  : cols_q;
      cur_r     = in_idle ? '0        : r_q;
      cur_c     = in_idle ? '0        : c_q;

      prod      = {{DIMW{1'b0}}, cur_r} * {{DIMW{1'b0}}, cur_cols};
      cur_addr  = cur_base + ADNW'(prod + {{DIMW{1'b0}}, cur_c});
      is_last   = (cur_r == cur_rows - ONE) && (cur_c == cur_cols - ONE);

      nxt_r = cur_r;
      nxt_c = cur_c;
      if (!cur_tr) begin
         if (cur_c == cur_cols - ONE) begin
            nxt_c = '0;
            nxt_r = cur_r + ONE;
         end else begin
            nxt_c = cur_c + ONE;
         end
      end else begin
         if (cur_r == cur_rows - ONE) begin
            nxt_r = '0;
            nxt_c = cur_c + ONE;
         end else begin
            nxt_r = cur_r + ONE;
         end
      end
   end

   // Reads still in the RAM pipe already own a FIFO slot; issue only when one is left.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CW'(pipe_vld_q[i]);
      end
      occupancy  = CW'(count_q) + inflight;
      credit_ok  = occupancy < CW'(FIFO_DEPTH);
      issue_fire = credit_ok && ((state_q == S_ISSUE) || (accept && !dims_zero));
   end

   always_comb begin
      m_valid   = (count_q != '0);
      m_data    = fifo_data_q[rd_ptr_q];
      m_last    = m_valid && fifo_last_q[rd_ptr_q];
      push      = pipe_vld_q[RD_LAT-1];
      pop       = m_valid && m_ready;
      ram_addrb = issue_fire ? cur_addr : addr_q;
      busy      = !in_idle || accept;
      done      = (state_q == S_DONE);
   end

   always_comb begin
      state_d     = state_q;
      transpose_d = transpose_q;
      base_d      = base_q;
      rows_d      = rows_q;
      cols_d      = cols_q;
      r_d         = r_q;
      c_d         = c_q;
      addr_d      = ram_addrb;
      pipe_vld_d  = {pipe_vld_q[RD_LAT-2:0], issue_fire};
      pipe_last_d = {pipe_last_q[RD_LAT-2:0], issue_fire && is_last};
      wr_ptr_d    = wr_ptr_q + PW'(push);
      rd_ptr_d    = rd_ptr_q + PW'(pop);
      count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               transpose_d = transpose;
               base_d      = base_addr;
               rows_d      = num_rows;
               cols_d      = num_cols;
               r_d         = '0;
               c_d         = '0;
               if (dims_zero) begin
                  state_d = S_DONE;
               end else if (issue_fire) begin
                  r_d     = nxt_r;
                  c_d     = nxt_c;
                  state_d = is_last ? S_DRAIN : S_ISSUE;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (issue_fire) begin
               if (is_last) begin
                  state_d = S_DRAIN;
               end else begin
                  r_d = nxt_r;
                  c_d = nxt_c;
               end
            end
         end
         S_DRAIN: begin
            if (pop && m_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         transpose_q <= 1'b0;
         base_q      <= '0;
         rows_q      <= '0;
         cols_q      <= '0;
         r_q         <= '0;
         c_q         <= '0;
         addr_q      <= '0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         transpose_q <= transpose_d;
         base_q      <= base_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         r_q         <= r_d;
         c_q         <= c_d;
         addr_q      <= addr_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Storage needs no reset: the cleared pointers and count make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= ram_doutb;
         fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LAT-1];
      end
   end

endmodule

// File: tb/tb_matrix_ram_reader.sv
// Bench for matrix_ram_reader: a 2-stage RAM model, a directed vector table, hand-built
// start/reset sequences and random tiles compared against an index-arithmetic walk model.
module tb_matrix_ram_reader;

   localparam int DW = 64;
   localparam int AW = 6;
   localparam int MW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          transpose;
   logic [AW-1:0] base_addr;
   logic [MW-1:0] num_rows;
   logic [MW-1:0] num_cols;
   logic [AW-1:0] ram_addrb;
   logic [DW-1:0] ram_doutb;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic          done;

   logic [DW-1:0] mem [64];
   logic [DW-1:0] ram_s1;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic          tr;
      logic [MW-1:0] base;
      logic [MW-1:0] rows;
      logic [MW-1:0] cols;
      int            mode;
      logic [DW-1:0] exp_first;
      logic [DW-1:0] exp_final;
      int            exp_n;
   } vec_t;

   beat_t got[$];
   beat_t exp_q[$];
   vec_t  vecs[5];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc, first_valid_cyc, last_cyc, done_cyc, done_cnt, busy_cnt;
   logic          track_start = 1'b0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_s1    <= mem[ram_addrb];
      ram_doutb <= ram_s1;
   end

   matrix_ram_reader #(
      .DATA_WIDTH(DW), .ADNW(AW), .DIMW(MW), .RD_LAT(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .transpose(transpose),
      .base_addr(base_addr), .num_rows(num_rows), .num_cols(num_cols),
      .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .done(done)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Samples at the falling edge (records beats, done, busy, stall stability), then returns just after the rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (track_start && start) begin
         start_cyc   = cyc;
         track_start = 1'b0;
      end
      if (prev_stall && !rst) begin
         check("stall_valid", 64'(m_valid), 64'd1);
         check("stall_data", m_data, prev_data);
         check("stall_last", 64'(m_last), 64'(prev_last));
      end
      prev_stall = m_valid && !m_ready && !rst;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready && !rst) begin
         got.push_back('{m_data, m_last});
         if (m_last) last_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
   endtask

   // Element i of the tile, by index arithmetic on the walk order.
   task automatic build_expected(input logic tr, input logic [MW-1:0] base,
                                 input logic [MW-1:0] rows, input logic [MW-1:0] cols);
      int n;
      int r;
      int c;
      int a;
      exp_q.delete();
      n = int'(rows) * int'(cols);
      for (int i = 0; i < n; i++) begin
         if (!tr) begin
            r = i / int'(cols);
            c = i % int'(cols);
         end else begin
            c = i / int'(rows);
            r = i % int'(rows);
         end
         a = (int'(base) + r * int'(cols) + c) % 64;
         exp_q.push_back('{mem[a], (i == n - 1)});
      end
   endtask

   task automatic run_tile(input string tag, input logic tr, input logic [MW-1:0] base,
                           input logic [MW-1:0] rows, input logic [MW-1:0] cols,
                           input int mode, input bit inject);
      int n;
      int k;
      int lasts;
      int lim;
      bit finished;
      build_expected(tr, base, rows, cols);
      n = exp_q.size();
      got.delete();
      done_cnt = 0;
      busy_cnt = 0;
      first_valid_cyc = -1;
      last_cyc = -1;
      done_cyc = -1;
      track_start = 1'b1;
      transpose = tr;
      base_addr = base;
      num_rows = rows;
      num_cols = cols;
      start = 1'b1;
      m_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      k = 0;
      finished = 1'b0;
      while (!finished && k < 800) begin
         if (inject && k == 2) begin
            start = 1'b1;
            transpose = ~tr;
            base_addr = base + 6'd17;
            num_rows = 6'd1;
            num_cols = 6'd1;
         end else begin
            start = 1'b0;
         end
         case (mode)
            1: m_ready = ($urandom_range(0, 3) != 0);
            2: m_ready = !(k >= 5 && k < 15);
            default: m_ready = 1'b1;
         endcase
         tick();
         k++;
         if (done_cnt > 0) finished = 1'b1;
      end
      check({tag, " done_seen"}, 64'(finished), 64'd1);
      start = 1'b0;
      m_ready = 1'b1;
      repeat (3) tick();

      check({tag, " beat_count"}, 64'(got.size()), 64'(n));
      lim = (got.size() < n) ? got.size() : n;
      lasts = 0;
      for (int i = 0; i < got.size(); i++) if (got[i].last) lasts++;
      for (int i = 0; i < lim; i++) begin
         check($sformatf("%s data[%0d]", tag, i), got[i].data, exp_q[i].data);
         check($sformatf("%s last[%0d]", tag, i), 64'(got[i].last), 64'(exp_q[i].last));
      end
      check({tag, " last_markers"}, 64'(lasts), (n > 0) ? 64'd1 : 64'd0);
      check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, " busy_len"}, 64'(busy_cnt), 64'(done_cyc - start_cyc + 1));
      check({tag, " busy_idle"}, 64'(busy), 64'd0);
      if (n == 0) begin
         check({tag, " no_valid"}, 64'(first_valid_cyc < 0), 64'd1);
         check({tag, " busy_zero_len"}, 64'(busy_cnt), 64'd2);
      end else begin
         check({tag, " first_valid_lat"}, 64'(first_valid_cyc - start_cyc), 64'd3);
         check({tag, " done_after_last"}, 64'(done_cyc - last_cyc), 64'd1);
      end
   endtask

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish before 5ms");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b0, 6'd4,  6'd2, 6'd3, 0, 64'd4,  64'd9,  6};
      vecs[1] = '{1'b1, 6'd4,  6'd2, 6'd3, 0, 64'd4,  64'd9,  6};
      vecs[2] = '{1'b0, 6'd0,  6'd4, 6'd4, 2, 64'd0,  64'd15, 16};
      vecs[3] = '{1'b0, 6'd62, 6'd1, 6'd4, 0, 64'd62, 64'd1,  4};
      vecs[4] = '{1'b0, 6'd5,  6'd0, 6'd3, 0, 64'd0,  64'd0,  0};

      for (int i = 0; i < 64; i++) mem[i] = 64'(i);
      rst = 1'b1;
      start = 1'b0;
      transpose = 1'b0;
      base_addr = '0;
      num_rows = '0;
      num_cols = '0;
      m_ready = 1'b0;
      repeat (2) tick();
      check("reset addrb", 64'(ram_addrb), 64'd0);
      check("reset m_valid", 64'(m_valid), 64'd0);
      check("reset m_last", 64'(m_last), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 5; v++) begin
         run_tile($sformatf("vec%0d", v), vecs[v].tr, vecs[v].base, vecs[v].rows,
                  vecs[v].cols, vecs[v].mode, 1'b0);
         check($sformatf("vec%0d count", v), 64'(got.size()), 64'(vecs[v].exp_n));
         if (vecs[v].exp_n > 0) begin
            check($sformatf("vec%0d first", v),
                  (got.size() > 0) ? got[0].data : 64'hDEAD_DEAD_DEAD_DEAD, vecs[v].exp_first);
            check($sformatf("vec%0d final", v),
                  (got.size() > 0) ? got[got.size()-1].data : 64'hDEAD_DEAD_DEAD_DEAD,
                  vecs[v].exp_final);
         end
      end

      run_tile("start_while_busy", 1'b0, 6'd4, 6'd2, 6'd3, 0, 1'b1);

      // Abandon a stalled 4x4 tile with data queued and reads in flight.
      transpose = 1'b0;
      base_addr = 6'd0;
      num_rows = 6'd4;
      num_cols = 6'd4;
      start = 1'b1;
      m_ready = 1'b0;
      tick();
      start = 1'b0;
      repeat (6) tick();
      check("pre_reset m_valid", 64'(m_valid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("post_reset m_valid", 64'(m_valid), 64'd0);
      check("post_reset busy", 64'(busy), 64'd0);
      check("post_reset m_last", 64'(m_last), 64'd0);
      m_ready = 1'b1;
      repeat (2) tick();
      run_tile("after_reset", 1'b1, 6'd10, 6'd2, 6'd3, 0, 1'b0);

      for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
      for (int t = 0; t < 20; t++) begin
         run_tile($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)),
                  6'($urandom_range(1, 7)), 1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
